// File: rtl/reg_file_sb_if.sv
// Decode/writeback bus for reg_file_sb: read ports, destination reservation,
// writeback and flush, plus the scoreboard status returned to decode.
interface reg_file_sb_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NREGS  = 32,
    parameter int unsigned ADDR_W = $clog2(NREGS),
    parameter int unsigned NUM_RD = 2
);
    localparam int unsigned CNT_W = $clog2(NREGS + 1);

    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     issue_valid;
    logic [ADDR_W-1:0]        issue_addr;
    logic                     issue_ready;
    logic                     wb_valid;
    logic [ADDR_W-1:0]        wb_addr;
    logic [DATA_W-1:0]        wb_data;
    logic                     flush;
    logic [CNT_W-1:0]         pending_cnt;

    modport master (
        output rd_addr, issue_valid, issue_addr, wb_valid, wb_addr, wb_data, flush,
        input  rd_data, rd_busy, issue_ready, pending_cnt
    );

    modport slave (
        input  rd_addr, issue_valid, issue_addr, wb_valid, wb_addr, wb_data, flush,
        output rd_data, rd_busy, issue_ready, pending_cnt
    );
endinterface

// File: rtl/reg_file_sb.sv
// Multi-read-port register file with write-first bypass, hardwired zero register
// and a per-register busy scoreboard with pending-write counter and flush.
module reg_file_sb #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NREGS    = 32,
    parameter int unsigned ADDR_W   = $clog2(NREGS),
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned ZERO_REG = NREGS - 1
) (
    input logic          clk,
    input logic          rst,
    reg_file_sb_if.slave bus
);
    localparam int unsigned       CNT_W    = $clog2(NREGS + 1);
    localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] mem_q [NREGS];
    logic [NREGS-1:0]  busy_q, busy_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] ra [NUM_RD];
    logic              wb_en, issue_acc, cnt_inc, cnt_dec;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_ra
        assign ra[i] = bus.rd_addr[i*ADDR_W +: ADDR_W];
    end

    always_comb begin
        bus.rd_data = '0;
        bus.rd_busy = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (!rst && ra[i] != ZeroAddr) begin
                // Same-cycle writeback wins over the stored value and its busy bit.
                if (bus.wb_valid && bus.wb_addr == ra[i]) begin
                    bus.rd_data[i*DATA_W +: DATA_W] = bus.wb_data;
                end else begin
                    bus.rd_data[i*DATA_W +: DATA_W] = mem_q[ra[i]];
                    bus.rd_busy[i]                  = busy_q[ra[i]];
                end
            end
        end
    end

    assign wb_en = bus.wb_valid && bus.wb_addr != ZeroAddr;

    assign bus.issue_ready = !rst && !bus.flush &&
                             (bus.issue_addr == ZeroAddr || !busy_q[bus.issue_addr] ||
                              (bus.wb_valid && bus.wb_addr == bus.issue_addr));

    assign issue_acc = bus.issue_valid && bus.issue_ready && bus.issue_addr != ZeroAddr;

    // A retiring write whose bit is re-reserved in the same cycle is a net no-op.
    assign cnt_inc = issue_acc && !busy_q[bus.issue_addr];
    assign cnt_dec = wb_en && busy_q[bus.wb_addr] &&
                     !(issue_acc && bus.issue_addr == bus.wb_addr);

    always_comb begin
        busy_d = busy_q;
        if (wb_en) begin
            busy_d[bus.wb_addr] = 1'b0;
        end
        if (issue_acc) begin
            busy_d[bus.issue_addr] = 1'b1;
        end
        if (bus.flush) begin
            busy_d = '0;
        end
    end

    always_comb begin
        cnt_d = cnt_q + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);
        if (bus.flush) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wb_en) begin
            mem_q[bus.wb_addr] <= bus.wb_data;
        end
    end

    assign bus.pending_cnt = cnt_q;
endmodule
